// File: rtl/crossing_block_arbiter_if.sv
// Request/response bundle between N client blocks and the shared adder arbiter.
// The slave modport is the arbiter side; the master modport is the client/consumer side.
interface crossing_block_arbiter_if #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2
);
    logic [N-1:0]   io_req_valid;
    logic [N-1:0]   io_req_ready;
    logic [N*W-1:0] io_req_a;
    logic [N*W-1:0] io_req_b;
    logic           io_resp_valid;
    logic           io_resp_ready;
    logic [W-1:0]   io_resp_o1;
    logic [W-1:0]   io_resp_o2;
    logic [IDW-1:0] io_resp_id;
    logic [15:0]    io_grant_count;

    modport slave (
        input  io_req_valid,
        input  io_req_a,
        input  io_req_b,
        input  io_resp_ready,
        output io_req_ready,
        output io_resp_valid,
        output io_resp_o1,
        output io_resp_o2,
        output io_resp_id,
        output io_grant_count
    );

    modport master (
        output io_req_valid,
        output io_req_a,
        output io_req_b,
        output io_resp_ready,
        input  io_req_ready,
        input  io_resp_valid,
        input  io_resp_o1,
        input  io_resp_o2,
        input  io_resp_id,
        input  io_grant_count
    );
endinterface

// File: rtl/crossing_block_arbiter.sv
// Round-robin arbiter sharing one adder (o1 = a, o2 = a + b) among N requesters,
// with a single registered valid/ready response slot tagged by requester index.
module crossing_block_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    crossing_block_arbiter_if.slave bus
);
    // state    | meaning
    // ST_EMPTY | response slot holds nothing
    // ST_FULL  | response slot holds a result awaiting io_resp_ready
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [W-1:0]   r_o1;
    logic [W-1:0]   r_o2;
    logic [15:0]    r_grant_count;

    logic [IDW-1:0] w_winner;
    logic [IDW-1:0] w_ptr_next;
    logic           w_found;
    logic           w_can_accept;
    logic           w_accept;
    logic [N-1:0]   w_ready;
    logic [W-1:0]   w_a;
    logic [W-1:0]   w_b;
    logic [W-1:0]   w_sum;

    // First valid requester at or after the pointer, wrapping modulo N.
    always_comb begin : arb_search
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(r_ptr) + i) % N;
            if (!w_found && bus.io_req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = IDW'(idx);
            end
        end
    end

    // Reset blocks acceptance so no client believes it was served during reset.
    assign w_can_accept = !reset && ((r_state == ST_EMPTY) || bus.io_resp_ready);
    assign w_accept     = w_can_accept && w_found;
    assign w_ready      = w_accept ? (N'(1) << w_winner) : '0;

    assign w_a   = bus.io_req_a[int'(w_winner)*W +: W];
    assign w_b   = bus.io_req_b[int'(w_winner)*W +: W];
    assign w_sum = w_a + w_b;

    assign w_ptr_next = (int'(w_winner) == N - 1) ? '0 : w_winner + 1'b1;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
            ST_FULL:  if (bus.io_resp_ready && !w_accept) w_state_next = ST_EMPTY;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_EMPTY;
            r_ptr         <= '0;
            r_id          <= '0;
            r_o1          <= '0;
            r_o2          <= '0;
            r_grant_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_o1          <= w_a;
                r_o2          <= w_sum;
                r_id          <= w_winner;
                r_ptr         <= w_ptr_next;
                r_grant_count <= r_grant_count + 16'd1;
            end
        end
    end

    assign bus.io_req_ready   = w_ready;
    assign bus.io_resp_valid  = (r_state == ST_FULL);
    assign bus.io_resp_o1     = r_o1;
    assign bus.io_resp_o2     = r_o2;
    assign bus.io_resp_id     = r_id;
    assign bus.io_grant_count = r_grant_count;
endmodule

// File: tb/tb_crossing_block_arbiter.sv
// Bench for crossing_block_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_crossing_block_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    crossing_block_arbiter_if #(.N(N), .W(W), .IDW(IDW)) bus_if ();

    crossing_block_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one response slot, a rotating priority pointer and a grant counter.
    bit       m_on = 1'b0;
    bit       m_valid;
    int       m_o1, m_o2, m_id, m_ptr, m_cnt;

    always @(negedge clk) begin
        int win;
        int opa, opb;
        bit acc;
        win = -1;
        if (reset) begin
            chk("ready_in_reset", 32'(bus_if.io_req_ready), 32'd0);
            m_on = 1'b1; m_valid = 1'b0;
            m_o1 = 0; m_o2 = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_on) begin
            for (int i = 0; i < N; i++) begin
                if (win < 0 && bus_if.io_req_valid[(m_ptr + i) % N]) win = (m_ptr + i) % N;
            end
            acc = (win >= 0) && (!m_valid || bus_if.io_resp_ready);
            chk("req_ready", 32'(bus_if.io_req_ready), acc ? (32'd1 << win) : 32'd0);
            chk("resp_valid", 32'(bus_if.io_resp_valid), 32'(m_valid));
            if (m_valid) begin
                chk("resp_o1", 32'(bus_if.io_resp_o1), m_o1);
                chk("resp_o2", 32'(bus_if.io_resp_o2), m_o2);
                chk("resp_id", 32'(bus_if.io_resp_id), m_id);
            end
            chk("grant_count", 32'(bus_if.io_grant_count), m_cnt);
            if (acc) begin
                opa     = int'(bus_if.io_req_a[win*W +: W]);
                opb     = int'(bus_if.io_req_b[win*W +: W]);
                m_valid = 1'b1;
                m_o1    = opa;
                m_o2    = (opa + opb) % 256;
                m_id    = win;
                m_ptr   = (win + 1) % N;
                m_cnt   = (m_cnt + 1) % 65536;
            end else if (bus_if.io_resp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [7:0] a, input logic [7:0] b);
        bus_if.io_req_a[k*W +: W] = a;
        bus_if.io_req_b[k*W +: W] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset                = 1'b1;
        bus_if.io_req_valid  = 4'hF;
        bus_if.io_req_a      = '0;
        bus_if.io_req_b      = '0;
        bus_if.io_resp_ready = 1'b1;

        // Reset with every requester asking.
        @(negedge clk);
        chk("t1_ready_during_reset", 32'(bus_if.io_req_ready), 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("t1_resp_valid", 32'(bus_if.io_resp_valid), 32'd0);
        chk("t1_grant_count", 32'(bus_if.io_grant_count), 32'd0);
        next_cycle();

        // Single requester 2.
        do_reset();
        bus_if.io_req_valid = 4'b0100;
        set_op(2, 8'h10, 8'h05);
        @(negedge clk);
        chk("t2_ready", 32'(bus_if.io_req_ready), 32'h4);
        next_cycle();
        bus_if.io_req_valid = 4'b0000;
        @(negedge clk);
        chk("t2_valid", 32'(bus_if.io_resp_valid), 32'd1);
        chk("t2_o1", 32'(bus_if.io_resp_o1), 32'h10);
        chk("t2_o2", 32'(bus_if.io_resp_o2), 32'h15);
        chk("t2_id", 32'(bus_if.io_resp_id), 32'd2);
        next_cycle();

        // Round robin with all requesters valid.
        do_reset();
        bus_if.io_req_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t3_grant", 32'(bus_if.io_req_ready), 32'd1 << (c % 4));
            next_cycle();
        end
        bus_if.io_req_valid = 4'h0;
        @(negedge clk);
        chk("t3_count", 32'(bus_if.io_grant_count), 32'd5);
        chk("t3_last_id", 32'(bus_if.io_resp_id), 32'd0);
        next_cycle();

        // Sum wraps modulo 256.
        bus_if.io_req_valid = 4'b0001;
        set_op(0, 8'hF0, 8'h20);
        @(negedge clk);
        next_cycle();
        set_op(0, 8'hFF, 8'h01);
        @(negedge clk);
        chk("t4_wrap_a", 32'(bus_if.io_resp_o2), 32'h10);
        next_cycle();
        bus_if.io_req_valid = 4'b0000;
        @(negedge clk);
        chk("t4_wrap_b", 32'(bus_if.io_resp_o2), 32'h00);
        next_cycle();

        // Backpressure: one accept, two held cycles, then drain-and-refill.
        @(negedge clk);
        next_cycle();
        bus_if.io_resp_ready = 1'b0;
        bus_if.io_req_valid  = 4'b0010;
        set_op(1, 8'h33, 8'h44);
        @(negedge clk);
        chk("t5_first_accept", 32'(bus_if.io_req_ready), 32'h2);
        next_cycle();
        set_op(1, 8'h55, 8'h01);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t5_hold_ready", 32'(bus_if.io_req_ready), 32'd0);
            chk("t5_hold_o1", 32'(bus_if.io_resp_o1), 32'h33);
            chk("t5_hold_o2", 32'(bus_if.io_resp_o2), 32'h77);
            chk("t5_hold_id", 32'(bus_if.io_resp_id), 32'd1);
            next_cycle();
        end
        bus_if.io_resp_ready = 1'b1;
        @(negedge clk);
        chk("t5_refill_ready", 32'(bus_if.io_req_ready), 32'h2);
        next_cycle();
        bus_if.io_req_valid = 4'b0000;
        @(negedge clk);
        chk("t5_refill_o1", 32'(bus_if.io_resp_o1), 32'h55);
        chk("t5_refill_o2", 32'(bus_if.io_resp_o2), 32'h56);
        next_cycle();

        // Reset while FULL with a non-zero pointer.
        bus_if.io_req_valid  = 4'b0100;
        bus_if.io_resp_ready = 1'b0;
        @(negedge clk);
        next_cycle();
        bus_if.io_req_valid = 4'b0000;
        do_reset();
        bus_if.io_req_valid  = 4'hF;
        bus_if.io_resp_ready = 1'b1;
        @(negedge clk);
        chk("t6_valid_cleared", 32'(bus_if.io_resp_valid), 32'd0);
        chk("t6_grant_req0", 32'(bus_if.io_req_ready), 32'h1);
        next_cycle();

        // Randomized traffic with occasional resets.
        repeat (2000) begin
            reset                = ($urandom_range(0, 63) == 0);
            bus_if.io_req_valid  = 4'($urandom_range(0, 15));
            bus_if.io_req_a      = 32'($urandom);
            bus_if.io_req_b      = 32'($urandom);
            bus_if.io_resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            next_cycle();
        end
        reset               = 1'b0;
        bus_if.io_req_valid = 4'h0;
        @(negedge clk);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
